// File: rtl/abcd_seq_pkg.sv
// Shared types for the ABCD pattern sequencer: FSM state encoding and the
// per-step pattern entry stored in the pattern RAM.
package abcd_seq_pkg;

  localparam int unsigned SEQ_HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    DONE
  } state_t;

  typedef struct packed {
    logic [3:0]            vec;
    logic [SEQ_HOLD_W-1:0] hold;
    logic                  exp;
  } step_t;

endpackage

// File: rtl/abcd_seq_pattern_ram.sv
// Pattern storage for the ABCD sequencer: NUM_STEPS entries, synchronous
// write, asynchronous read. Contents are intentionally not reset.
module abcd_seq_pattern_ram
  import abcd_seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  step_t             wr_data,
  input  logic [STEP_W-1:0] rd_addr,
  output step_t             rd_data
);

  step_t mem [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/abcd_pattern_sequencer.sv
// Replays programmed {a,b,c,d} vectors, each held hold+1 cycles, for a 3-of-4
// majority detector. Define CAPTURE_EN to add f_in mismatch capture.
module abcd_pattern_sequencer
  import abcd_seq_pkg::*;
#(
  parameter  int unsigned NUM_STEPS = 8,
  parameter  int unsigned HOLD_W    = SEQ_HOLD_W,
  localparam int unsigned STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_vec,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              cfg_exp,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              step_valid,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              done
`ifdef CAPTURE_EN
  ,
  input  logic              f_in,
  output logic [7:0]        mismatch_cnt,
  output logic [STEP_W-1:0] last_miss
`endif
);

  localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_STEPS - 1);

  state_t            state_q, state_d;
  logic [3:0]        vec_q, vec_d;
  logic [STEP_W-1:0] idx_q, idx_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic              wr_en;
  step_t             wr_entry, rd_entry, load_entry;
  logic [STEP_W-1:0] rd_addr;
  logic              load;
  logic              step_end;

  always_comb begin
    busy              = (state_q == LOAD) || (state_q == HOLD);
    step_valid        = (state_q == LOAD);
    done              = (state_q == DONE);
    step_idx          = idx_q;
    {a, b, c, d}      = vec_q;
    wr_en             = cfg_we && !busy;
    wr_entry          = '0;
    wr_entry.vec      = cfg_vec;
    wr_entry.hold     = SEQ_HOLD_W'(cfg_hold);
    wr_entry.exp      = cfg_exp;
  end

  abcd_seq_pattern_ram #(
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cfg_addr),
    .wr_data (wr_entry),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

  // A write and a start in the same cycle must launch step 0 with the new data.
  always_comb begin
    load_entry = (wr_en && (cfg_addr == rd_addr)) ? wr_entry : rd_entry;
  end

  always_comb begin
    load     = 1'b0;
    step_end = 1'b0;
    rd_addr  = '0;
    case (state_q)
      IDLE: begin
        load = start && !abort;
      end
      LOAD, HOLD: begin
        if (cnt_q == '0) begin
          step_end = 1'b1;
          if (idx_q != LAST_IDX) begin
            load    = 1'b1;
            rd_addr = idx_q + 1'b1;
          end else begin
            load = loop;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD, HOLD: begin
        if (cnt_q != '0) begin
          state_d = HOLD;
          cnt_d   = cnt_q - 1'b1;
        end else if (!load) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
    if (load) begin
      state_d = LOAD;
      idx_d   = rd_addr;
      vec_d   = load_entry.vec;
      cnt_d   = HOLD_W'(load_entry.hold);
    end
    if (abort) begin
      state_d = IDLE;
      vec_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CAPTURE_EN
  logic              exp_q, exp_d;
  logic [7:0]        miss_q, miss_d;
  logic [STEP_W-1:0] lmiss_q, lmiss_d;

  // exp travels with the vector so the end-of-step compare needs no second read port.
  always_comb begin
    exp_d   = exp_q;
    miss_d  = miss_q;
    lmiss_d = lmiss_q;
    if (load) begin
      exp_d = load_entry.exp;
    end
    if ((state_q == IDLE) && start && !abort) begin
      miss_d  = '0;
      lmiss_d = '0;
    end else if (step_end && !abort && (f_in != exp_q)) begin
      if (miss_q != 8'hFF) begin
        miss_d = miss_q + 1'b1;
      end
      lmiss_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q   <= 1'b0;
      miss_q  <= '0;
      lmiss_q <= '0;
    end else begin
      exp_q   <= exp_d;
      miss_q  <= miss_d;
      lmiss_q <= lmiss_d;
    end
  end

  always_comb begin
    mismatch_cnt = miss_q;
    last_miss    = lmiss_q;
  end
`else
  logic unused_exp;
  always_comb begin
    unused_exp = load_entry.exp;
  end
`endif

endmodule

// File: tb/tb_abcd_pattern_sequencer.sv
// Bench for abcd_pattern_sequencer: directed scenarios plus random traffic,
// checked every cycle against a schedule-based model of the sequence.
`timescale 1ns/1ps
module tb_abcd_pattern_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          loop = 1'b0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_addr = '0;
  logic [3:0]    cfg_vec = '0;
  logic [7:0]    cfg_hold = '0;
  logic          cfg_exp = 1'b0;
  logic          a, b, c, d, step_valid, busy, done;
  logic [SW-1:0] step_idx;
`ifdef CAPTURE_EN
  logic          f_in;
  logic [7:0]    mismatch_cnt;
  logic [SW-1:0] last_miss;
  assign f_in = ($countones({a, b, c, d}) >= 3);
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  abcd_pattern_sequencer #(
    .NUM_STEPS (NS),
    .HOLD_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .loop       (loop),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_vec    (cfg_vec),
    .cfg_hold   (cfg_hold),
    .cfg_exp    (cfg_exp),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .step_valid (step_valid),
    .step_idx   (step_idx),
    .busy       (busy),
    .done       (done)
`ifdef CAPTURE_EN
    ,
    .f_in         (f_in),
    .mismatch_cnt (mismatch_cnt),
    .last_miss    (last_miss)
`endif
  );

  // Expected outputs for one cycle; a pass is expanded into a queue of these.
  typedef struct packed {
    logic [3:0]    vec;
    logic [SW-1:0] idx;
    logic          sv;
    logic          bsy;
    logic          dn;
    logic          last;
    logic          ex;
  } rec_t;

  rec_t       cur;
  rec_t       q[$];
  logic [3:0] m_vec [NS];
  int         m_hold [NS];
  logic       m_exp [NS];
  int         m_miss;
  int         m_lmiss;
  bit         m_idle;

  function automatic void expand();
    rec_t r;
    for (int i = 0; i < int'(NS); i++) begin
      for (int k = 0; k <= m_hold[i]; k++) begin
        r      = '0;
        r.vec  = m_vec[i];
        r.idx  = SW'(i);
        r.sv   = (k == 0);
        r.bsy  = 1'b1;
        r.last = (k == m_hold[i]);
        r.ex   = m_exp[i];
        q.push_back(r);
      end
    end
  endfunction

  function automatic logic maj(input logic [3:0] v);
    return ($countones(v) >= 3);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     = '0;
      q.delete();
      m_miss  = 0;
      m_lmiss = 0;
    end else begin
      m_idle = !cur.bsy && !cur.dn;
      if (cfg_we && !cur.bsy) begin
        m_vec[cfg_addr]  = cfg_vec;
        m_hold[cfg_addr] = int'(cfg_hold);
        m_exp[cfg_addr]  = cfg_exp;
      end
      if (cur.bsy && cur.last && !abort && (maj(cur.vec) != cur.ex)) begin
        if (m_miss < 255) m_miss++;
        m_lmiss = int'(cur.idx);
      end
      if (abort) begin
        cur = '0;
        q.delete();
      end else if (m_idle && start) begin
        m_miss  = 0;
        m_lmiss = 0;
        expand();
        cur = q.pop_front();
      end else if (cur.bsy) begin
        if (q.size() != 0) begin
          cur = q.pop_front();
        end else if (loop) begin
          expand();
          cur = q.pop_front();
        end else begin
          cur.sv   = 1'b0;
          cur.bsy  = 1'b0;
          cur.dn   = 1'b1;
          cur.last = 1'b0;
        end
      end else if (cur.dn) begin
        cur.dn = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({a, b, c, d} !== cur.vec || step_idx !== cur.idx || step_valid !== cur.sv ||
        busy !== cur.bsy || done !== cur.dn) begin
      errors++;
      $display("FAIL cycle t=%0t got vec=%b idx=%0d sv=%b busy=%b done=%b required vec=%b idx=%0d sv=%b busy=%b done=%b",
               $time, {a, b, c, d}, step_idx, step_valid, busy, done,
               cur.vec, cur.idx, cur.sv, cur.bsy, cur.dn);
    end
`ifdef CAPTURE_EN
    checks++;
    if (mismatch_cnt !== 8'(m_miss) || last_miss !== SW'(m_lmiss)) begin
      errors++;
      $display("FAIL capture t=%0t got cnt=%0d last=%0d required cnt=%0d last=%0d",
               $time, mismatch_cnt, last_miss, m_miss, m_lmiss);
    end
`endif
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h required=%0h", nm, $time, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int idx, input logic [3:0] v, input int h, input logic e);
    cfg_we   = 1'b1;
    cfg_addr = SW'(idx);
    cfg_vec  = v;
    cfg_hold = 8'(h);
    cfg_exp  = e;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  logic [3:0] lv [8] = '{4'hC, 4'hE, 4'hE, 4'hE, 4'h7, 4'h7, 4'h1, 4'h1};
  int         li [8] = '{0, 1, 1, 1, 2, 2, 3, 3};
  logic       ls [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    tick(3);
    @(negedge clk);
    chk("reset_outputs", 32'({a, b, c, d, step_valid, busy, done, step_idx}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    wr(0, 4'hC, 0, 1'b0);
    wr(1, 4'hE, 2, 1'b1);
    wr(2, 4'h7, 1, 1'b1);
    wr(3, 4'h1, 0, 1'b0);

    // Four-step run; a start and a write to entry 3 arrive mid-run and must be ignored.
    loop = 1'b0;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("seq_vec", 32'({a, b, c, d}), 32'(lv[k]));
      chk("seq_idx", 32'(step_idx), 32'(li[k]));
      chk("seq_valid", 32'(step_valid), 32'(ls[k]));
      chk("seq_done", 32'(done), 32'(k == 7));
      chk("model_vec", 32'(cur.vec), 32'(lv[k]));
      if (k == 1) begin
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 2'd3;
        cfg_vec  = 4'hF;
        cfg_hold = 8'd5;
      end
      if (k == 2) begin
        start  = 1'b0;
        cfg_we = 1'b0;
      end
    end
    tick(2);

    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_valid", 32'(step_valid), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < int'(NS); i++) wr(i, (i % 2 == 0) ? 4'hA : 4'h5, 0, 1'b0);
    loop = 1'b1;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("loop_idx", 32'(step_idx), 32'(k % 4));
      chk("loop_vec", 32'({a, b, c, d}), (k % 2 == 0) ? 32'hA : 32'h5);
      if (k == 9) abort = 1'b1;
    end
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_vec", 32'({a, b, c, d}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    loop = 1'b0;
    @(posedge clk);
    #1;

    wr(0, 4'hA, 3, 1'b0);
    pulse_start();
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({a, b, c, d, step_valid, busy, done, step_idx}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    @(negedge clk);
    chk("restart_idx", 32'(step_idx), 32'd0);
    chk("restart_vec", 32'({a, b, c, d}), 32'hA);
    chk("restart_valid", 32'(step_valid), 32'd1);
    tick(8);

`ifdef CAPTURE_EN
    wr(0, 4'hC, 0, 1'b0);
    wr(1, 4'hE, 2, 1'b1);
    wr(2, 4'h7, 1, 1'b1);
    wr(3, 4'h1, 0, 1'b0);
    pulse_start();
    tick(10);
    chk("cap_clean_cnt", 32'(mismatch_cnt), 32'd0);
    wr(2, 4'h7, 1, 1'b0);
    pulse_start();
    tick(10);
    chk("cap_one_cnt", 32'(mismatch_cnt), 32'd1);
    chk("cap_one_last", 32'(last_miss), 32'd2);
    for (int i = 0; i < int'(NS); i++) wr(i, 4'hF, 0, 1'b0);
    loop = 1'b1;
    pulse_start();
    tick(280);
    chk("cap_sat", 32'(mismatch_cnt), 32'd255);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    loop  = 1'b0;
    tick(2);
    chk("cap_kept", 32'(mismatch_cnt), 32'd255);
    pulse_start();
    @(negedge clk);
    chk("cap_clear", 32'(mismatch_cnt), 32'd0);
    tick(6);
`endif

    repeat (1500) begin
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) loop = ~loop;
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = SW'($urandom_range(0, NS - 1));
      cfg_vec  = 4'($urandom);
      cfg_hold = 8'($urandom_range(0, 3));
      cfg_exp  = 1'($urandom);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    start  = 1'b0;
    abort  = 1'b0;
    cfg_we = 1'b0;
    rst_n  = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
